// File: rtl/fcu_pkg.sv
// Shared FCU definitions: datapath widths, exception encoding and the
// writeback entry record buffered between the FCU and the ROB.
package fcu_pkg;

  localparam int WID  = 80;
  localparam int TAGW = 5;

  localparam logic [7:0]  FLT_NONE = 8'h00;
  localparam logic [15:0] MISP_MAX = 16'hFFFF;

  typedef struct packed {
    logic [TAGW-1:0] id;
    logic [WID-1:0]  bus;
    logic [WID-1:0]  tgt;
    logic [7:0]      exc;
    logic            misp;
  } wb_entry_t;

endpackage

// File: rtl/fcu_wb_fifo2.sv
// Two-entry writeback FIFO: 1-bit read/write pointers, 2-bit occupancy.
// Flush clears pointers and count; the payload array is never reset.
module fcu_wb_fifo2
  import fcu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  wb_entry_t  wdata,
  output wb_entry_t  rdata,
  output logic [1:0] count
);

  wb_entry_t  mem_q [2];
  wb_entry_t  mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  always_comb begin
    do_push  = push & (count_q != 2'd2) & ~flush;
    do_pop   = pop & (count_q != 2'd0) & ~flush;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    rdata = mem_q[rd_ptr_q];
    count = count_q;
  end

endmodule

// File: rtl/fcu_wb.sv
// FCU writeback stage: tags each result with a misprediction flag, buffers
// it in a 2-entry FIFO and counts mispredicted results as they retire.
module fcu_wb #(
  parameter int WID  = fcu_pkg::WID,
  parameter int TAGW = fcu_pkg::TAGW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_v,
  output logic            in_rdy,
  input  logic [TAGW-1:0] in_id,
  input  logic [WID-1:0]  in_bus,
  input  logic [WID-1:0]  in_tgt,
  input  logic [WID-1:0]  in_ptgt,
  input  logic [7:0]      in_exc,
  output logic            out_v,
  input  logic            out_rdy,
  output logic [TAGW-1:0] out_id,
  output logic [WID-1:0]  out_bus,
  output logic [WID-1:0]  out_tgt,
  output logic [7:0]      out_exc,
  output logic            out_misp,
  output logic [15:0]     misp_cnt
);

  import fcu_pkg::*;

  wb_entry_t   wr_ent;
  wb_entry_t   rd_ent;
  logic [1:0]  count;
  logic        deq;
  logic [15:0] misp_cnt_q, misp_cnt_d;

  // A faulting result never counts as a misprediction, whatever its targets.
  always_comb begin
    wr_ent.id   = in_id;
    wr_ent.bus  = in_bus;
    wr_ent.tgt  = in_tgt;
    wr_ent.exc  = in_exc;
    wr_ent.misp = (in_exc == FLT_NONE) && (in_tgt != in_ptgt);
  end

  fcu_wb_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (in_v),
    .pop   (out_rdy),
    .wdata (wr_ent),
    .rdata (rd_ent),
    .count (count)
  );

  always_comb begin
    in_rdy   = (count != 2'd2);
    out_v    = (count != 2'd0);
    out_id   = rd_ent.id;
    out_bus  = rd_ent.bus;
    out_tgt  = rd_ent.tgt;
    out_exc  = rd_ent.exc;
    out_misp = rd_ent.misp;
    misp_cnt = misp_cnt_q;
  end

  always_comb begin
    deq        = out_v & out_rdy & ~flush;
    misp_cnt_d = misp_cnt_q;
    if (deq && rd_ent.misp && (misp_cnt_q != MISP_MAX)) begin
      misp_cnt_d = misp_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misp_cnt_q <= '0;
    end else begin
      misp_cnt_q <= misp_cnt_d;
    end
  end

endmodule

// File: tb/tb_fcu_wb.sv
// Scoreboard bench for fcu_wb: expected results are queued at acceptance and
// compared by a monitor whenever the DUT presents a valid output.
module tb_fcu_wb;

  localparam int W = 80;
  localparam int T = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_v = 1'b0;
  logic          in_rdy;
  logic [T-1:0]  in_id = '0;
  logic [W-1:0]  in_bus = '0;
  logic [W-1:0]  in_tgt = '0;
  logic [W-1:0]  in_ptgt = '0;
  logic [7:0]    in_exc = '0;
  logic          out_v;
  logic          out_rdy = 1'b0;
  logic [T-1:0]  out_id;
  logic [W-1:0]  out_bus;
  logic [W-1:0]  out_tgt;
  logic [7:0]    out_exc;
  logic          out_misp;
  logic [15:0]   misp_cnt;

  fcu_wb #(.WID(W), .TAGW(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_v     (in_v),
    .in_rdy   (in_rdy),
    .in_id    (in_id),
    .in_bus   (in_bus),
    .in_tgt   (in_tgt),
    .in_ptgt  (in_ptgt),
    .in_exc   (in_exc),
    .out_v    (out_v),
    .out_rdy  (out_rdy),
    .out_id   (out_id),
    .out_bus  (out_bus),
    .out_tgt  (out_tgt),
    .out_exc  (out_exc),
    .out_misp (out_misp),
    .misp_cnt (misp_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [T-1:0] id;
    logic [W-1:0] bus;
    logic [W-1:0] tgt;
    logic [7:0]   exc;
    logic         misp;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        pend;
  int unsigned exp_cnt = 0;
  int          errors = 0;
  int          checks = 0;
  bit          live = 0;
  bit          acc = 0;
  bit          deq = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] r80();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Stimulus side: decide acceptance from the reference occupancy.
  always @(negedge clk) begin
    acc = 0;
    if (live) begin
      chk("in_rdy", W'(in_rdy), W'(exp_q.size() < 2));
      if (rst_n && in_v && exp_q.size() < 2 && !flush) begin
        acc       = 1;
        pend.id   = in_id;
        pend.bus  = in_bus;
        pend.tgt  = in_tgt;
        pend.exc  = in_exc;
        pend.misp = (in_exc != 8'h00) ? 1'b0 : (in_tgt != in_ptgt);
      end
    end
  end

  // Monitor side: compare whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    deq = 0;
    if (live) begin
      chk("out_v", W'(out_v), W'(exp_q.size() != 0));
      chk("misp_cnt", W'(misp_cnt), W'(exp_cnt));
      if (exp_q.size() != 0) begin
        chk("out_id", W'(out_id), W'(exp_q[0].id));
        chk("out_bus", out_bus, exp_q[0].bus);
        chk("out_tgt", out_tgt, exp_q[0].tgt);
        chk("out_exc", W'(out_exc), W'(exp_q[0].exc));
        chk("out_misp", W'(out_misp), W'(exp_q[0].misp));
        deq = rst_n && out_rdy && !flush;
      end
    end
  end

  // Reference state update at the clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 0;
      live = 1;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (deq && exp_q.size() != 0) begin
        if (exp_q[0].misp && exp_cnt < 65535) exp_cnt++;
        void'(exp_q.pop_front());
      end
      if (acc) exp_q.push_back(pend);
    end
  end

  task automatic drive(input bit v, input int id, input logic [W-1:0] tgt,
                       input logic [W-1:0] ptgt, input logic [7:0] exc,
                       input bit ordy, input bit fl = 0);
    in_v    = v;
    in_id   = T'(id);
    in_bus  = r80();
    in_tgt  = tgt;
    in_ptgt = ptgt;
    in_exc  = exc;
    out_rdy = ordy;
    flush   = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] t;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, '0, '0, 8'h00, 1);

    // Single result, one-cycle latency.
    drive(1, 3, W'('h100), W'('h100), 8'h00, 1);
    drive(0, 0, '0, '0, 8'h00, 1);
    drive(0, 0, '0, '0, 8'h00, 1);

    // Fill to full, third offer refused, then drain in order.
    drive(1, 1, W'('h10), W'('h10), 8'h00, 0);
    drive(1, 2, W'('h20), W'('h20), 8'h00, 0);
    drive(1, 7, W'('h30), W'('h30), 8'h00, 0);
    repeat (3) drive(0, 0, '0, '0, 8'h00, 1);

    // Mispredict counted; faulting mispredict is not.
    drive(1, 4, W'('h200), W'('h208), 8'h00, 1);
    drive(0, 0, '0, '0, 8'h00, 1);
    drive(1, 5, W'('h200), W'('h208), 8'h05, 1);
    drive(0, 0, '0, '0, 8'h00, 1);

    // Simultaneous enqueue/dequeue at count 1, across pointer wrap.
    drive(1, 6, W'('h40), W'('h40), 8'h00, 0);
    drive(1, 8, W'('h50), W'('h58), 8'h00, 1);
    drive(1, 9, W'('h60), W'('h60), 8'h00, 1);
    repeat (2) drive(0, 0, '0, '0, 8'h00, 1);

    // Flush with a full FIFO overrides enqueue and dequeue.
    drive(1, 10, W'('h70), W'('h71), 8'h00, 0);
    drive(1, 11, W'('h80), W'('h81), 8'h00, 0);
    drive(1, 12, W'('h90), W'('h91), 8'h00, 1, 1);
    repeat (2) drive(0, 0, '0, '0, 8'h00, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      t = r80();
      drive(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)), t,
            ($urandom_range(0, 1) != 0) ? t : r80(),
            ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
            bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 30) == 0));
    end
    repeat (3) drive(0, 0, '0, '0, 8'h00, 1);

    // Drive the counter into saturation and beyond.
    for (int i = 0; i < 65540; i++) begin
      drive(1, i & 31, W'(i), W'(i + 1), 8'h00, 1);
    end
    repeat (2) drive(0, 0, '0, '0, 8'h00, 1);

    // Reset mid-stream, colliding with flush and both handshakes.
    drive(1, 13, W'('h1), W'('h2), 8'h00, 0);
    rst_n = 1'b0;
    drive(1, 14, W'('h3), W'('h4), 8'h00, 1, 1);
    rst_n = 1'b1;
    drive(1, 15, W'('h5), W'('h6), 8'h00, 1);
    repeat (3) drive(0, 0, '0, '0, 8'h00, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
